// File: rtl/trap_seq.sv
// Machine-mode trap sequencer: writes mepc and mcause, then redirects fetch to mtvec.
// Also forwards CSR instruction writes to the CSR file write port while idle.
module trap_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    output logic            trap_ready,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_data,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_EPC   = 2'd1,
        WR_CAUSE = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic            trap_acc;

    // Nothing is accepted while reset is sampled, so a trap cannot slip past it.
    assign trap_acc = trap_valid && trap_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (trap_acc) state_d = WR_EPC;
            WR_EPC:   state_d = WR_CAUSE;
            WR_CAUSE: state_d = REDIRECT;
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            if (trap_acc) begin
                pc_q    <= trap_pc;
                cause_q <= trap_cause;
            end
        end
    end

    // Output decode from state and live inputs; instruction writes pass through with zero latency.
    always_comb begin
        trap_ready     = 1'b0;
        req_ready      = 1'b0;
        csr_we         = 1'b0;
        csr_waddr      = req_addr;
        csr_wdata      = req_data;
        csr_raddr      = CSR_MTVEC;
        redirect_valid = 1'b0;
        redirect_pc    = csr_rdata & ~XLEN'(3);
        busy           = 1'b1;
        case (state_q)
            IDLE: begin
                busy       = 1'b0;
                trap_ready = !rst;
                req_ready  = !rst && !trap_valid;
                csr_we     = req_valid && req_ready;
            end
            WR_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = pc_q;
            end
            WR_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cause_q;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_seq.sv
// Scoreboard bench for trap_seq: stimulus pushes expected CSR writes and redirects,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_trap_seq;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            trap_valid;
    logic            trap_ready;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_cause;
    logic            req_valid;
    logic            req_ready;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_data;
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;

    trap_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_pc(trap_pc), .trap_cause(trap_cause),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]     a;
        logic [XLEN-1:0] d;
        int              c;
    } wr_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        int              c;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];

    int              n_vec = 0;
    int              n_err = 0;
    int              cyc = 0;
    bit              mon_en = 1'b0;
    bit              rv_prev = 1'b0;
    logic [XLEN-1:0] rpc_hold = '0;
    logic [XLEN-1:0] mtvec = 32'h0000_0203;

    // Small CSR file model: only mtvec matters to the sequencer.
    assign csr_rdata = (csr_raddr == 12'h305) ? mtvec : '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (csr_we === 1'b1 && csr_waddr == 12'h305) mtvec <= csr_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int exp_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (trap_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("idle_reached", 64'(seen), 64'd1);
        chk("idle_cycle", 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic push_trap(input int n, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause,
                             input logic [XLEN-1:0] rpc, input int rcyc);
        wq.push_back('{a: 12'h341, d: pc, c: n + 1});
        wq.push_back('{a: 12'h342, d: cause, c: n + 2});
        rq.push_back('{pc: rpc, c: rcyc});
    endtask

    // Monitor: every CSR write and every redirect handshake must match the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (csr_we === 1'b1) begin
                if (wq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL csr_unexpected: got write %0h<=%0h expected none (cycle %0d)",
                             csr_waddr, csr_wdata, cyc);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("csr_waddr", 64'(csr_waddr), 64'(w.a));
                    chk("csr_wdata", 64'(csr_wdata), 64'(w.d));
                    chk("csr_cycle", 64'(cyc), 64'(w.c));
                end
            end
            if (redirect_valid === 1'b1) begin
                if (!rv_prev) rpc_hold = redirect_pc;
                else chk("redirect_pc_stable", 64'(redirect_pc), 64'(rpc_hold));
                chk("redirect_trap_ready", 64'(trap_ready), 64'd0);
                chk("redirect_busy", 64'(busy), 64'd1);
                if (redirect_ready === 1'b1) begin
                    if (rq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL redirect_unexpected: got pc %0h expected none (cycle %0d)",
                                 redirect_pc, cyc);
                    end else begin
                        rd_t r;
                        r = rq.pop_front();
                        chk("redirect_pc", 64'(redirect_pc), 64'(r.pc));
                        chk("redirect_cycle", 64'(cyc), 64'(r.c));
                    end
                end
            end
            rv_prev = (redirect_valid === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; trap_valid = 1'b0; trap_pc = '0; trap_cause = '0;
        req_valid = 1'b0; req_addr = '0; req_data = '0; redirect_ready = 1'b1;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_csr_we", 64'(csr_we), 64'd0);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_csr_raddr", 64'(csr_raddr), 64'h305);
        step(); rst = 1'b0; mon_en = 1'b1;
        @(negedge clk);
        chk("idle_trap_ready", 64'(trap_ready), 64'd1);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // Basic trap: mtvec 0x203 gives redirect 0x200, idle again at N+4
        step(); n = cyc;
        trap_valid = 1'b1; trap_pc = 32'h0000_0100; trap_cause = 32'h2;
        push_trap(n, 32'h100, 32'h2, 32'h200, n + 3);
        @(negedge clk);
        chk("t1_trap_ready", 64'(trap_ready), 64'd1);
        step(); trap_valid = 1'b0;
        @(negedge clk);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_req_ready_busy", 64'(req_ready), 64'd0);
        wait_idle(n + 4);

        // Instruction write in IDLE, zero latency, no busy
        step(); n = cyc;
        req_valid = 1'b1; req_addr = 12'h341; req_data = 32'hDEAD_BEEC;
        wq.push_back('{a: 12'h341, d: 32'hDEAD_BEEC, c: n});
        @(negedge clk);
        chk("t2_req_ready", 64'(req_ready), 64'd1);
        chk("t2_busy", 64'(busy), 64'd0);
        step(); req_valid = 1'b0;
        @(negedge clk);
        chk("t2_busy_after", 64'(busy), 64'd0);

        // Trap and write together: trap wins, write lands once IDLE returns
        step(); n = cyc;
        trap_valid = 1'b1; trap_pc = 32'h0000_0200; trap_cause = 32'hB;
        req_valid = 1'b1; req_addr = 12'h305; req_data = 32'h0000_0400;
        push_trap(n, 32'h200, 32'hB, 32'h200, n + 3);
        wq.push_back('{a: 12'h305, d: 32'h400, c: n + 4});
        @(negedge clk);
        chk("t3_req_ready", 64'(req_ready), 64'd0);
        chk("t3_trap_ready", 64'(trap_ready), 64'd1);
        step(); trap_valid = 1'b0;
        wait_idle(n + 4);
        chk("t3_req_ready_late", 64'(req_ready), 64'd1);
        step(); req_valid = 1'b0;

        // Redirect stalled 5 cycles, mtvec now 0x400
        step(); n = cyc;
        trap_valid = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'h7; redirect_ready = 1'b0;
        push_trap(n, 32'h300, 32'h7, 32'h400, n + 8);
        step(); trap_valid = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("t4_redirect_held", 64'(redirect_valid), 64'd1);
        chk("t4_trap_ready", 64'(trap_ready), 64'd0);
        step(); redirect_ready = 1'b1;
        wait_idle(n + 9);

        // Reset during WR_CAUSE abandons the sequence
        step(); n = cyc;
        trap_valid = 1'b1; trap_pc = 32'h0000_0500; trap_cause = 32'h3;
        wq.push_back('{a: 12'h341, d: 32'h500, c: n + 1});
        wq.push_back('{a: 12'h342, d: 32'h3, c: n + 2});
        step(); trap_valid = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_csr_we", 64'(csr_we), 64'd0);
        chk("t5_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("t5_trap_ready", 64'(trap_ready), 64'd1);
        repeat (4) step();

        // Back-to-back traps: second held valid, accepted only at IDLE
        step(); n = cyc;
        trap_valid = 1'b1; trap_pc = 32'h0000_0600; trap_cause = 32'h4;
        push_trap(n, 32'h600, 32'h4, 32'h400, n + 3);
        push_trap(n + 4, 32'h700, 32'h5, 32'h400, n + 7);
        step(); trap_pc = 32'h0000_0700; trap_cause = 32'h5;
        @(negedge clk);
        chk("t6_trap_ready_busy", 64'(trap_ready), 64'd0);
        wait_idle(n + 4);
        step(); trap_valid = 1'b0;
        wait_idle(n + 8);

        repeat (3) step();
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
